// File: rtl/seg_size_scheduler_pkg.sv
// Shared constants, candidate table and FSM state type for the segmentation scheduler.
package seg_pkg;

    localparam int K_PLUS_BYTES  = 768;
    localparam int K_MINUS_BYTES = 132;
    localparam int CB_CRC_BYTES  = 3;
    localparam int MAX_TB_BYTES  = 1659;

    typedef struct packed {
        logic [1:0]  cplus;
        logic [1:0]  cminus;
        logic [15:0] cap;
    } cand_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        PUSH = 2'd2,
        ERR  = 2'd3
    } state_e;

    // Payload capacity: per-block CRC only exists once the TB is split into several blocks.
    function automatic logic [15:0] cand_cap(input int cp, input int cm);
        int raw;
        raw = cp * K_PLUS_BYTES + cm * K_MINUS_BYTES;
        if ((cp + cm) > 1) begin
            raw = raw - (cp + cm) * CB_CRC_BYTES;
        end else begin
            raw = raw;
        end
        return 16'(raw);
    endfunction

    localparam cand_t CAND_TABLE [0:4] = '{
        '{2'd0, 2'd1, cand_cap(0, 1)},
        '{2'd1, 2'd0, cand_cap(1, 0)},
        '{2'd1, 2'd1, cand_cap(1, 1)},
        '{2'd2, 2'd0, cand_cap(2, 0)},
        '{2'd2, 2'd1, cand_cap(2, 1)}
    };

endpackage

// File: rtl/seg_size_scheduler_cand_rom.sv
// Combinational candidate lookup: index -> {C+, C-, capacity}, ascending capacity order.
module seg_cand_rom
    import seg_pkg::*;
(
    input  logic [2:0] idx,
    output cand_t      cand
);

    // Table lookup; out-of-range indices yield an empty candidate.
    always_comb begin
        case (idx)
            3'd0:    cand = CAND_TABLE[0];
            3'd1:    cand = CAND_TABLE[1];
            3'd2:    cand = CAND_TABLE[2];
            3'd3:    cand = CAND_TABLE[3];
            3'd4:    cand = CAND_TABLE[4];
            default: cand = '{2'd0, 2'd0, 16'd0};
        endcase
    end

endmodule

// File: rtl/seg_size_scheduler.sv
// Segmentation-parameter scheduler: picks the smallest fitting code-block set and pushes {C+,C-,F}.
// Optional SEG_STATS_EN adds saturating success/error counters.
module seg_size_scheduler
    import seg_pkg::*;
#(
    parameter int TB_W = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            tb_valid,
    output logic            tb_ready,
    input  logic [TB_W-1:0] tb_bytes,
    input  logic            size_fifo_full,
    output logic            size_wreq,
    output logic [19:0]     size_data,
    output logic            seg_err
`ifdef SEG_STATS_EN
    ,
    output logic [15:0]     stat_ok,
    output logic [15:0]     stat_err
`endif
);

    state_e          state_r, next_state_s;
    logic [2:0]      idx_r;
    logic [TB_W-1:0] b_r;
    logic [19:0]     data_r;
    logic            ready_r, err_r;
    cand_t           cand_s;
    logic [TB_W-1:0] cap_s, fill_s;
    logic            accept_s, match_s, inc_s;

    seg_cand_rom u_rom (
        .idx  (idx_r),
        .cand (cand_s)
    );

    assign cap_s  = TB_W'(cand_s.cap);
    assign fill_s = cap_s - b_r;

    // Next-state and control decode.
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        match_s      = 1'b0;
        inc_s        = 1'b0;
        case (state_r)
            IDLE: begin
                if (tb_valid && ready_r) begin
                    accept_s     = 1'b1;
                    next_state_s = EVAL;
                end else begin
                    next_state_s = IDLE;
                end
            end
            EVAL: begin
                if (b_r == {TB_W{1'b0}}) begin
                    next_state_s = ERR;
                end else if (cap_s >= b_r) begin
                    match_s      = 1'b1;
                    next_state_s = PUSH;
                end else if (idx_r == 3'd4) begin
                    next_state_s = ERR;
                end else begin
                    inc_s        = 1'b1;
                    next_state_s = EVAL;
                end
            end
            PUSH: begin
                if (!size_fifo_full) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = PUSH;
                end
            end
            ERR:     next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // State, request and result registers; ready/err are registered from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            idx_r   <= 3'd0;
            b_r     <= {TB_W{1'b0}};
            data_r  <= 20'd0;
            ready_r <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= next_state_s;
            ready_r <= (next_state_s == IDLE);
            err_r   <= (next_state_s == ERR);
            if (accept_s) begin
                b_r   <= tb_bytes;
                idx_r <= 3'd0;
            end else if (inc_s) begin
                idx_r <= idx_r + 3'd1;
            end
            if (match_s) begin
                data_r <= {cand_s.cplus, cand_s.cminus, 16'(fill_s)};
            end
        end
    end

    assign tb_ready  = ready_r;
    assign size_wreq = (state_r == PUSH) && !size_fifo_full;
    assign size_data = data_r;
    assign seg_err   = err_r;

`ifdef SEG_STATS_EN
    logic [15:0] ok_cnt_r, err_cnt_r;

    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            ok_cnt_r  <= 16'd0;
            err_cnt_r <= 16'd0;
        end else begin
            if (size_wreq && (ok_cnt_r != 16'hFFFF)) begin
                ok_cnt_r <= ok_cnt_r + 16'd1;
            end
            if (seg_err && (err_cnt_r != 16'hFFFF)) begin
                err_cnt_r <= err_cnt_r + 16'd1;
            end
        end
    end

    assign stat_ok  = ok_cnt_r;
    assign stat_err = err_cnt_r;
`endif

endmodule

// File: tb/tb_seg_size_scheduler.sv
// Self-checking bench for seg_size_scheduler: directed vector table, reset corner cases, random requests.
module tb_seg_size_scheduler;

    logic        clk = 1'b0;
    logic        reset, tb_valid, tb_ready, size_fifo_full, size_wreq, seg_err;
    logic [15:0] tb_bytes;
    logic [19:0] size_data;
`ifdef SEG_STATS_EN
    logic [15:0] stat_ok, stat_err;
`endif

    int n_vec = 0;
    int n_bad = 0;
    int m_ok  = 0;
    int m_err = 0;

    always #5 clk = ~clk;

    seg_size_scheduler #(.TB_W(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .tb_valid       (tb_valid),
        .tb_ready       (tb_ready),
        .tb_bytes       (tb_bytes),
        .size_fifo_full (size_fifo_full),
        .size_wreq      (size_wreq),
        .size_data      (size_data),
        .seg_err        (seg_err)
`ifdef SEG_STATS_EN
        ,
        .stat_ok        (stat_ok),
        .stat_err       (stat_err)
`endif
    );

    typedef struct {
        logic [15:0] b;
        int          fs;
        int          fl;
        logic        ok;
        logic [19:0] data;
        int          cyc;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, got, got, exp, exp);
        end
    endtask

    // Reference: try block combinations smallest-capacity first; cycle counts are relative to the handshake.
    task automatic model(input logic [15:0] b, input int fs, input int fl,
                         output logic ok, output logic [19:0] data, output int cyc);
        int cp [5] = '{0, 1, 1, 2, 2};
        int cm [5] = '{1, 0, 1, 0, 1};
        int cap;
        ok = 1'b0; data = 20'd0; cyc = 6;
        if (b == 16'd0) begin
            cyc = 2;
        end else begin
            for (int k = 0; k < 5; k++) begin
                cap = cp[k] * 768 + cm[k] * 132 - ((cp[k] + cm[k] > 1) ? 3 * (cp[k] + cm[k]) : 0);
                if (!ok && cap >= int'(b)) begin
                    ok   = 1'b1;
                    data = {2'(cp[k]), 2'(cm[k]), 16'(cap - int'(b))};
                    cyc  = 2 + k;
                end
            end
            if (ok) begin
                while (cyc >= fs && cyc < fs + fl) cyc++;
            end
        end
    endtask

    task automatic run_req(input string nm, input vec_t v);
        int wq_cyc = -1, er_cyc = -1, rdy_cyc = -1, nwq = 0, ner = 0, waited = 0;
        logic [19:0] got_data = 20'd0;
        while (!tb_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check({nm, " ready_before"}, {31'd0, tb_ready}, 32'd1);
        tb_valid = 1'b1;
        tb_bytes = v.b;
        @(posedge clk);
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            tb_valid       = 1'b0;
            size_fifo_full = (n >= v.fs) && (n < v.fs + v.fl);
            #1;
            if (size_wreq) begin
                nwq++;
                if (wq_cyc < 0) begin
                    wq_cyc   = n;
                    got_data = size_data;
                end
            end
            if (seg_err) begin
                ner++;
                if (er_cyc < 0) er_cyc = n;
            end
            if (tb_ready) begin
                rdy_cyc = n;
                break;
            end
        end
        size_fifo_full = 1'b0;
        if (v.ok) begin
            m_ok++;
            check({nm, " wreq_count"}, nwq, 32'd1);
            check({nm, " err_count"}, ner, 32'd0);
            check({nm, " wreq_cycle"}, wq_cyc, v.cyc);
            check({nm, " size_data"}, {12'd0, got_data}, {12'd0, v.data});
        end else begin
            m_err++;
            check({nm, " wreq_count"}, nwq, 32'd0);
            check({nm, " err_count"}, ner, 32'd1);
            check({nm, " err_cycle"}, er_cyc, v.cyc);
        end
        check({nm, " ready_return"}, rdy_cyc, v.cyc + 1);
    endtask

    vec_t vt[$];
    vec_t rv;
    int   sel;
    int   edges [10] = '{132, 133, 768, 769, 894, 895, 1530, 1531, 1659, 1660};

    initial begin
        reset = 1'b1; tb_valid = 1'b0; tb_bytes = 16'd0; size_fifo_full = 1'b0;

        vt.push_back('{16'd100,   0, 0,  1'b1, 20'h10020, 2});
        vt.push_back('{16'd769,   0, 0,  1'b1, 20'h5007D, 4});
        vt.push_back('{16'd1659,  0, 0,  1'b1, 20'h90000, 6});
        vt.push_back('{16'd768,   0, 0,  1'b1, 20'h40000, 3});
        vt.push_back('{16'd133,   0, 0,  1'b1, 20'h4027B, 3});
        vt.push_back('{16'd1660,  0, 0,  1'b0, 20'h00000, 6});
        vt.push_back('{16'd0,     0, 0,  1'b0, 20'h00000, 2});
        vt.push_back('{16'd900,   5, 10, 1'b1, 20'h80276, 15});
        vt.push_back('{16'd132,   0, 0,  1'b1, 20'h10000, 2});
        vt.push_back('{16'd1,     0, 0,  1'b1, 20'h10083, 2});
        vt.push_back('{16'd894,   0, 0,  1'b1, 20'h50000, 4});
        vt.push_back('{16'd895,   0, 0,  1'b1, 20'h8027B, 5});
        vt.push_back('{16'd1531,  0, 0,  1'b1, 20'h90080, 6});
        vt.push_back('{16'd65535, 0, 0,  1'b0, 20'h00000, 6});
        vt.push_back('{16'd100,   1, 3,  1'b1, 20'h10020, 4});

        // Reset state
        repeat (3) @(negedge clk);
        check("rst tb_ready", {31'd0, tb_ready}, 32'd0);
        check("rst size_wreq", {31'd0, size_wreq}, 32'd0);
        check("rst seg_err", {31'd0, seg_err}, 32'd0);
        check("rst size_data", {12'd0, size_data}, 32'd0);
`ifdef SEG_STATS_EN
        check("rst stat_ok", {16'd0, stat_ok}, 32'd0);
        check("rst stat_err", {16'd0, stat_err}, 32'd0);
`endif
        reset = 1'b0;
        @(negedge clk);
        check("post_rst tb_ready", {31'd0, tb_ready}, 32'd1);

        for (int i = 0; i < vt.size(); i++) begin
            run_req($sformatf("vec%0d", i), vt[i]);
        end

        // Reset while the scheduler is walking the candidate table
        tb_valid = 1'b1; tb_bytes = 16'd1660;
        @(posedge clk);
        @(negedge clk); tb_valid = 1'b0;
        @(negedge clk); reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            check("midrst tb_ready", {31'd0, tb_ready}, 32'd0);
            check("midrst wreq_err", {30'd0, size_wreq, seg_err}, 32'd0);
        end
        reset = 1'b0;
        @(negedge clk); #1;
        check("midrst ready_after", {31'd0, tb_ready}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); #1;
            check("midrst no_event", {30'd0, size_wreq, seg_err}, 32'd0);
        end
        m_ok = 0; m_err = 0;
`ifdef SEG_STATS_EN
        check("midrst stat_ok", {16'd0, stat_ok}, 32'd0);
        check("midrst stat_err", {16'd0, stat_err}, 32'd0);
`endif

        // Random requests against the reference model
        for (int i = 0; i < 150; i++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0)      rv.b = 16'd0;
            else if (sel < 4)  rv.b = 16'(edges[$urandom_range(0, 9)]);
            else if (sel == 4) rv.b = 16'($urandom_range(1660, 65535));
            else               rv.b = 16'($urandom_range(1, 1659));
            rv.fs = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 7);
            rv.fl = $urandom_range(0, 6);
            model(rv.b, rv.fs, rv.fl, rv.ok, rv.data, rv.cyc);
            run_req($sformatf("rnd%0d_b%0d", i, rv.b), rv);
        end

`ifdef SEG_STATS_EN
        @(negedge clk);
        check("stat_ok total", {16'd0, stat_ok}, m_ok);
        check("stat_err total", {16'd0, stat_err}, m_err);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
